// File: rtl/divisor_sequencial_if.sv
// Handshake and operand/result bundle between the arithmetic controller
// (master) and the sequential divider (slave).
interface divisor_sequencial_if #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
);
    logic                  start;
    logic [DIVIDEND_W-1:0] dividendo;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVIDEND_W-1:0] quociente;
    logic [DIVISOR_W-1:0]  resto;
    logic                  busy;
    logic                  done;
    logic                  div_zero;

    modport master (
        output start, dividendo, divisor,
        input  quociente, resto, busy, done, div_zero
    );

    modport slave (
        input  start, dividendo, divisor,
        output quociente, resto, busy, done, div_zero
    );
endinterface

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// The dividend register doubles as the quotient shift register: each
// iteration consumes its MSB and shifts the new quotient bit in at the LSB.
module divisor_sequencial #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    divisor_sequencial_if.slave bus
);
    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nxt;
    logic                  accept, iterate, busy_c, done_c;

    logic [DIVIDEND_W-1:0] dvd;
    logic [DIVISOR_W-1:0]  dvs;
    logic [DIVISOR_W-1:0]  rem;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] quociente_q;
    logic [DIVISOR_W-1:0]  resto_q;
    logic                  div_zero_q;

    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W-1:0]  diff;
    logic                  borrow;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  rem_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state, handshake outputs and datapath enables
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy_c  = 1'b1;
                iterate = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                // A start seen here is taken exactly as in IDLE
                done_c    = 1'b1;
                state_nxt = IDLE;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = (bus.divisor == '0) ? DONE : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Trial subtraction; the low DIVISOR_W bits of the modular difference
    // are exact whenever there is no borrow, since the true difference < dvs
    always_comb begin
        trial   = {rem, dvd[DIVIDEND_W-1]};
        borrow  = (trial < {1'b0, dvs});
        diff    = trial[DIVISOR_W-1:0] - dvs;
        q_bit   = ~borrow;
        rem_nxt = borrow ? trial[DIVISOR_W-1:0] : diff;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            cnt         <= '0;
            quociente_q <= '0;
            resto_q     <= '0;
            div_zero_q  <= 1'b0;
        end else if (accept) begin
            dvd <= bus.dividendo;
            dvs <= bus.divisor;
            rem <= '0;
            cnt <= '0;
            if (bus.divisor == '0) begin
                quociente_q <= '1;
                resto_q     <= '0;
                div_zero_q  <= 1'b1;
            end
        end else if (iterate) begin
            dvd <= {dvd[DIVIDEND_W-2:0], q_bit};
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                quociente_q <= {dvd[DIVIDEND_W-2:0], q_bit};
                resto_q     <= rem_nxt;
                div_zero_q  <= 1'b0;
            end
        end
    end

    assign bus.quociente = quociente_q;
    assign bus.resto     = resto_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
endmodule
